// File: rtl/cpu_run_sequencer.sv
// Batch sequencer: issues a series of CPU start pulses, times each run with a
// saturating counter, and aborts the batch through an optional per-run watchdog.
module cpu_run_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_go,
    input  logic [3:0]  host_runs,
    input  logic [15:0] timeout_limit,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic        busy,
    output logic        finished,
    output logic        timeout_err,
    output logic [15:0] last_cycles,
    output logic [3:0]  runs_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_REPORT
    } state_t;

    state_t      r_state;
    logic        r_go_pend;
    logic [3:0]  r_runs;
    logic [15:0] r_limit;
    logic [15:0] r_cnt;
    logic        r_cpu_start;
    logic        r_busy;
    logic        r_finished;
    logic        r_timeout_err;
    logic [15:0] r_last_cycles;
    logic [3:0]  r_runs_done;

    logic [15:0] w_cnt_inc;
    logic [3:0]  w_runs_inc;
    logic        w_limit_hit;

    assign w_cnt_inc   = (r_cnt == 16'hFFFF) ? 16'hFFFF : r_cnt + 16'd1;
    assign w_runs_inc  = r_runs_done + 4'd1;
    assign w_limit_hit = (r_limit != '0) && (w_cnt_inc == r_limit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_go_pend     <= 1'b0;
            r_runs        <= '0;
            r_limit       <= '0;
            r_cnt         <= '0;
            r_cpu_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_finished    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_last_cycles <= '0;
            r_runs_done   <= '0;
        end else begin
            // NOTE: pulse outputs default low here so every branch below only sets them when needed.
            r_cpu_start <= 1'b0;
            r_finished  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A request is captured on one edge and acted on the next.
                    if (r_go_pend) begin
                        r_go_pend     <= 1'b0;
                        r_state       <= S_START;
                        r_cpu_start   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_runs_done   <= '0;
                        r_timeout_err <= 1'b0;
                        r_last_cycles <= '0;
                    end else if (host_go && (host_runs != '0)) begin
                        r_go_pend <= 1'b1;
                        r_runs    <= host_runs;
                        r_limit   <= timeout_limit;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // Completion takes priority over a watchdog expiry in the same cycle.
                    if (cpu_done) begin
                        r_last_cycles <= w_cnt_inc;
                        r_runs_done   <= w_runs_inc;
                        if (w_runs_inc == r_runs) begin
                            r_state    <= S_REPORT;
                            r_finished <= 1'b1;
                        end else begin
                            r_state <= S_GAP;
                        end
                    end else if (w_limit_hit) begin
                        r_timeout_err <= 1'b1;
                        r_last_cycles <= r_limit;
                        r_state       <= S_REPORT;
                        r_finished    <= 1'b1;
                    end
                end
                S_GAP: begin
                    r_state     <= S_START;
                    r_cpu_start <= 1'b1;
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_start   = r_cpu_start;
    assign busy        = r_busy;
    assign finished    = r_finished;
    assign timeout_err = r_timeout_err;
    assign last_cycles = r_last_cycles;
    assign runs_done   = r_runs_done;

endmodule

// File: doc/cpu_run_sequencer.md
CPU_RUN_SEQUENCER -- requirements
Module: cpu_run_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-low reset; sampled on rising clk edge only.
REQ-003 SHALL have port host_go, input, 1 bit: host request to begin a batch of runs.
REQ-004 SHALL have port host_runs, input, 4 bits: number of consecutive CPU runs in the batch, 1..15.
REQ-005 SHALL have port timeout_limit, input, 16 bits: per-run watchdog in cycles; 0 disables the watchdog.
REQ-006 SHALL have port cpu_start, output, 1 bit: start pulse to the CPU.
REQ-007 SHALL have port cpu_done, input, 1 bit: completion indication from the CPU.
REQ-008 SHALL have port busy, output, 1 bit: batch in progress.
REQ-009 SHALL have port finished, output, 1 bit: one-cycle pulse when a batch ends, normally or by timeout.
REQ-010 SHALL have port timeout_err, output, 1 bit: sticky watchdog flag.
REQ-011 SHALL have port last_cycles, output, 16 bits: cycle count of the most recent run.
REQ-012 SHALL have port runs_done, output, 4 bits: runs completed in the current or last batch.

Function
REQ-013 SHALL implement FSM states IDLE, START, WAIT, GAP, REPORT; all outputs registered.
REQ-014 IDLE: busy=0; host_go=1 with host_runs!=0 SHALL latch host_runs and timeout_limit, clear runs_done, timeout_err and last_cycles, and go to START.
REQ-015 IDLE: host_go=1 with host_runs=0 SHALL be ignored; the FSM stays in IDLE and no outputs change.
REQ-016 START: cpu_start=1 for exactly this one cycle; run counter cleared to 0; next state WAIT.
REQ-017 cpu_start SHALL be 0 in every state except START.
REQ-018 WAIT: run counter SHALL increment by 1 each cycle and saturate at 0xFFFF.
REQ-019 WAIT with cpu_done=1: last_cycles = counter+1 (saturating); runs_done increments.
REQ-020 After the increment in REQ-019, next state SHALL be REPORT if runs_done equals the latched run count, otherwise GAP.
REQ-021 WAIT: if the latched limit is nonzero, cpu_done=0, and counter+1 equals the limit, then timeout_err=1, last_cycles=limit, runs_done unchanged, next state REPORT.
REQ-022 cpu_done and the timeout condition in the same cycle: done SHALL win; timeout_err stays 0.
REQ-023 GAP: one cycle with cpu_start=0, so consecutive start pulses are separated by at least one low cycle; next state START.
REQ-024 REPORT: finished=1 for one cycle; next state IDLE.
REQ-025 busy SHALL be 1 in START, WAIT, GAP and REPORT.
REQ-026 cpu_done in IDLE, START, GAP or REPORT SHALL be ignored.
REQ-027 host_go while busy=1 SHALL be ignored; latched run count and limit are not altered mid-batch.
REQ-028 last_cycles, runs_done and timeout_err SHALL hold their values in IDLE until the next accepted host_go.
REQ-029 Latency: host_go sampled at edge k -> cpu_start high in the cycle after edge k+1, i.e. start is asserted during the START state that edge k+1 enters.
REQ-030 Latency: cpu_done in the first WAIT cycle SHALL yield last_cycles=1.

Reset
REQ-031 rst=0 at a rising edge SHALL force IDLE, with cpu_start=0, busy=0, finished=0, timeout_err=0, last_cycles=0, runs_done=0, and the run counter at 0.
REQ-032 Reset asserted mid-batch (any state) SHALL abort the batch immediately, with no finished pulse and no further cpu_start.
REQ-033 host_go sampled in the same cycle as rst=0 SHALL be discarded.

Verification
REQ-034 Single run: host_runs=1, limit=0, cpu_done 5 cycles after start -> one cpu_start pulse, last_cycles=5, runs_done=1, finished pulse, timeout_err=0.
REQ-035 Batch: host_runs=3, done 2 cycles after each start -> three one-cycle start pulses each separated by at least 1 low cycle, runs_done=3, finished exactly once.
REQ-036 Timeout: limit=10, done never asserted -> timeout_err=1, last_cycles=10, runs_done=0, finished on the cycle after the 10th WAIT cycle.
REQ-037 Tie: limit=4 and cpu_done on the 4th WAIT cycle -> timeout_err=0, last_cycles=4, runs_done=1.
REQ-038 Ignored inputs: host_runs=0 with go -> busy stays 0; go during a batch and spurious done in GAP -> no change to run count or outputs.
REQ-039 Reset mid-WAIT: rst=0 for 1 cycle -> all outputs 0 next cycle, no finished pulse; a new host_go afterwards starts a clean batch.
